// File: rtl/simple_pmp_pkg.sv
// Shared constants and types for the sequential PMP checker: A-field encodings,
// cfg-byte bit positions, M-mode privilege encoding and the FSM state type.
package simple_pmp_pkg;

    localparam logic [1:0] PMP_OFF   = 2'd0;
    localparam logic [1:0] PMP_TOR   = 2'd1;
    localparam logic [1:0] PMP_NA4   = 2'd2;
    localparam logic [1:0] PMP_NAPOT = 2'd3;

    localparam int CFG_R    = 0;
    localparam int CFG_W    = 1;
    localparam int CFG_X    = 2;
    localparam int CFG_A_LO = 3;
    localparam int CFG_A_HI = 4;
    localparam int CFG_L    = 7;

    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } pmp_state_e;

endpackage

// File: rtl/simple_pmp_checker_if.sv
// Request/response handshake bundle between a requester (master) and the PMP
// checker (slave).
interface simple_pmp_checker_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic [33:0] req_addr_i;
    logic [2:0]  req_access_i;
    logic [1:0]  req_priv_i;

    logic        resp_valid_o;
    logic        resp_ready_i;
    logic        resp_allow_o;
    logic        resp_matched_o;
    logic [3:0]  resp_idx_o;

    modport master (
        output req_valid_i, req_addr_i, req_access_i, req_priv_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_allow_o, resp_matched_o, resp_idx_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_access_i, req_priv_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_allow_o, resp_matched_o, resp_idx_o
    );

endinterface

// File: rtl/simple_pmp_entry_match.sv
// Combinational evaluation of a single PMP entry: address match for the entry's
// A mode and whether the requested access bits are all granted by R/W/X.
module simple_pmp_entry_match
    import simple_pmp_pkg::*;
(
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_access,
    input  logic [7:0]  i_cfg,
    input  logic [31:0] i_pmpaddr,
    input  logic [31:0] i_pmpaddr_prev,
    input  logic        i_is_entry0,
    output logic        o_match,
    output logic        o_perm_ok
);

    logic [1:0]  w_mode;
    logic [31:0] w_tor_lower;
    logic [31:0] w_napot_mask;
    logic [2:0]  w_perms;

    assign w_mode      = i_cfg[CFG_A_HI:CFG_A_LO];
    assign w_tor_lower = i_is_entry0 ? 32'd0 : i_pmpaddr_prev;
    assign w_perms     = {i_cfg[CFG_X], i_cfg[CFG_W], i_cfg[CFG_R]};

    // p ^ (p+1) sets the k trailing ones plus the first zero; all-ones p yields a zero mask.
    assign w_napot_mask = ~(i_pmpaddr ^ (i_pmpaddr + 32'd1));

    always_comb begin
        o_match = 1'b0;
        case (w_mode)
            PMP_TOR:   o_match = (i_addr >= w_tor_lower) && (i_addr < i_pmpaddr);
            PMP_NA4:   o_match = (i_addr == i_pmpaddr);
            PMP_NAPOT: o_match = ((i_addr ^ i_pmpaddr) & w_napot_mask) == 32'd0;
            default:   o_match = 1'b0;
        endcase
    end

    assign o_perm_ok = (i_access & w_perms) == i_access;

endmodule

// File: rtl/simple_pmp_checker.sv
// Sequential PMP checker: scans one entry per cycle, first match wins.
// Optional deny counter built only when SIMPLE_PMP_DENY_CNT_EN is defined.
module simple_pmp_checker
    import simple_pmp_pkg::*;
#(
    parameter int NrPMPEntries = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [127:0]         pmpcfg_i,
    input  logic [511:0]         pmpaddr_i,
    simple_pmp_checker_if.slave  bus,
    output logic [15:0]          deny_cnt_o
);

    localparam logic [3:0] LAST_IDX = (NrPMPEntries > 0) ? 4'(NrPMPEntries - 1) : 4'd0;

    pmp_state_e  r_state;
    logic [3:0]  r_idx;
    logic [31:0] r_addr;
    logic [2:0]  r_access;
    logic [1:0]  r_priv;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_allow;
    logic        r_matched;
    logic [3:0]  r_resp_idx;

    logic [3:0]  w_idx_prev;
    logic [7:0]  w_cfg;
    logic [31:0] w_pmpaddr;
    logic [31:0] w_pmpaddr_prev;
    logic        w_match;
    logic        w_perm_ok;
    logic        w_hit_allow;

    // Config is read live: a CSR write mid-scan only affects entries not yet visited.
    assign w_idx_prev     = r_idx - 4'd1;
    assign w_cfg          = pmpcfg_i[{r_idx, 3'b000} +: 8];
    assign w_pmpaddr      = pmpaddr_i[{r_idx, 5'b00000} +: 32];
    assign w_pmpaddr_prev = pmpaddr_i[{w_idx_prev, 5'b00000} +: 32];

    simple_pmp_entry_match u_entry_match (
        .i_addr         (r_addr),
        .i_access       (r_access),
        .i_cfg          (w_cfg),
        .i_pmpaddr      (w_pmpaddr),
        .i_pmpaddr_prev (w_pmpaddr_prev),
        .i_is_entry0    (r_idx == 4'd0),
        .o_match        (w_match),
        .o_perm_ok      (w_perm_ok)
    );

    assign w_hit_allow = ((r_priv == PRIV_M) && !w_cfg[CFG_L]) || w_perm_ok;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_idx        <= 4'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_allow      <= 1'b0;
            r_matched    <= 1'b0;
            r_resp_idx   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid_i && r_req_ready) begin
                        r_addr      <= bus.req_addr_i[33:2];
                        r_access    <= bus.req_access_i;
                        r_priv      <= bus.req_priv_i;
                        r_idx       <= 4'd0;
                        r_req_ready <= 1'b0;
                        if (NrPMPEntries == 0) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_allow      <= (bus.req_priv_i == PRIV_M);
                            r_matched    <= 1'b0;
                            r_resp_idx   <= 4'd0;
                        end else begin
                            r_state <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (w_match) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_allow      <= w_hit_allow;
                        r_matched    <= 1'b1;
                        r_resp_idx   <= r_idx;
                    end else if (r_idx == LAST_IDX) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_allow      <= (r_priv == PRIV_M);
                        r_matched    <= 1'b0;
                        r_resp_idx   <= 4'd0;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready_i) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o    = r_req_ready;
    assign bus.resp_valid_o   = r_resp_valid;
    assign bus.resp_allow_o   = r_allow;
    assign bus.resp_matched_o = r_matched;
    assign bus.resp_idx_o     = r_resp_idx;

`ifdef SIMPLE_PMP_DENY_CNT_EN
    logic [15:0] r_deny_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_deny_cnt <= 16'd0;
        end else if (r_resp_valid && bus.resp_ready_i && !r_allow && (r_deny_cnt != 16'hFFFF)) begin
            r_deny_cnt <= r_deny_cnt + 16'd1;
        end
    end

    assign deny_cnt_o = r_deny_cnt;
`else
    assign deny_cnt_o = 16'd0;
`endif

endmodule

// File: doc/simple_pmp_checker.md
# simple_pmp_checker

Sequential physical-memory-protection checker sitting directly downstream of the CSR register file. It consumes the live `pmpcfg_o`/`pmpaddr_o` buses and answers one access-permission query at a time over a valid/ready handshake. It scans PMP entries one per cycle, lowest index first, stops at the first match, and returns allow/deny with the matching index. LSU/fetch-side requesters sit upstream of its request port.

## Interface
- `NrPMPEntries`, default 8: number of active entries; legal values 0..16. Entries at or above this index are never scanned.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk_i`.
- `pmpcfg_i`  in  128  16 config bytes. Byte i layout: [0]=R, [1]=W, [2]=X, [4:3]=A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), [7]=L.
- `pmpaddr_i`  in  512  16×32-bit pmpaddr, each holding address bits [33:2].
- `req_valid_i`  in  1  query valid.
- `req_ready_o`  out  1  checker idle and able to accept.
- `req_addr_i`  in  34  physical byte address.
- `req_access_i`  in  3  one-hot access type: [0]=read, [1]=write, [2]=exec.
- `req_priv_i`  in  2  privilege level; 2'b11 = M-mode.
- `resp_valid_o`  out  1  response valid.
- `resp_ready_i`  in  1  response consumed.
- `resp_allow_o`  out  1  access permitted.
- `resp_matched_o`  out  1  an entry matched.
- `resp_idx_o`  out  4  index of the matching entry; 0 when `resp_matched_o`=0.
- `deny_cnt_o`  out  16  saturating count of denied responses (see Configuration).

## Operation
- FSM states:
  - IDLE: `req_ready_o`=1. A request is accepted when `req_valid_i` and `req_ready_o` are both high. On acceptance, `req_addr_i`, `req_access_i` and `req_priv_i` are registered, the index is cleared, and the FSM goes to SCAN. If `NrPMPEntries`=0, it goes straight to RESP with no match.
  - SCAN: evaluates entry `idx` against the registered address, reading `pmpcfg_i`/`pmpaddr_i` live.
    - On a match: go to RESP.
    - On no match with `idx`=NrPMPEntries-1: go to RESP with no match.
    - Otherwise: `idx`+1.
  - RESP: `resp_valid_o`=1, outputs held stable until `resp_ready_i`. The cycle after the handshake, the FSM returns to IDLE.
- Matching, with a = addr[33:2] and p = pmpaddr[i]:
  - OFF: never matches.
  - TOR: matches when pmpaddr[i-1] ≤ a < p. For i=0 the lower bound is 0. If lower ≥ upper, the entry does not match.
  - NA4: matches when a == p.
  - NAPOT: k = count of trailing ones in p; the entry matches when a and p agree on bits [31:k+1]. p=32'hFFFF_FFFF matches every address.
- Permission check:
  - On a match, `perm_ok` = (access & cfg[2:0]) == access.
  - M-mode with L=0 is allowed regardless of R/W/X.
  - M-mode with L=1 uses `perm_ok`; non-M modes also use `perm_ok`.
- No match: allow = (priv == M).
- No snapshot of the config. A CSR write landing mid-scan affects only entries not yet scanned.

## Timing
- Reset values:
  - `req_ready_o`=1.
  - `resp_valid_o`, `resp_allow_o`, `resp_matched_o`=0.
  - `resp_idx_o`=0, `deny_cnt_o`=0.
  - FSM state = IDLE.
- All response outputs are registered.
- Latency: with acceptance at edge T, entry i is evaluated in cycle T+1+i.
  - A match at entry i gives `resp_valid_o` high from T+2+i.
  - No match gives `resp_valid_o` high from T+1+N.
  - N=0 gives `resp_valid_o` high from T+1.
- Throughput is one query in flight. `req_ready_o`=0 in SCAN and RESP.
- Back-to-back: a new request may be accepted in the first IDLE cycle after the response handshake.
- Reset asserted mid-SCAN or mid-RESP: the next edge forces IDLE, drops any pending response and clears outputs; the counter returns to 0.
- `req_access_i`=0 is legal. It always passes `perm_ok`.

## Configuration
- `SIMPLE_PMP_DENY_CNT_EN` defined: a 16-bit counter increments once per response handshake with `resp_allow_o`=0. It saturates at 16'hFFFF and is cleared only by reset.
- `SIMPLE_PMP_DENY_CNT_EN` undefined: no counter logic is built and `deny_cnt_o` is tied to 0.

## Structure
- Package `simple_pmp_pkg` holds:
  - A-field constants (`PMP_OFF`/`PMP_TOR`/`PMP_NA4`/`PMP_NAPOT`).
  - cfg bit positions (R, W, X, A, L).
  - M-mode privilege encoding.
  - FSM state typedef (IDLE/SCAN/RESP).
- One combinational sub-module `simple_pmp_entry_match`:
  - Inputs: addr, cfg byte, pmpaddr[i], pmpaddr[i-1], an is-entry-0 flag.
  - Outputs: match, `perm_ok`.
  - The top instantiates it once and muxes its inputs by `idx`.

## Test plan
- Reset then idle: `req_ready_o`=1, `resp_valid_o`=0, `deny_cnt_o`=0.
- NAPOT allow:
  - Setup: cfg0=8'h1B (NAPOT, R, W), pmpaddr0=32'h2000_01FF. Query addr 34'h8000_0100, read, U-mode, accepted at T.
  - Required: `resp_valid_o` at T+2, allow=1, matched=1, idx=0.
- TOR priority:
  - Setup: cfg0 OFF; cfg1=8'h0C (TOR, X) with pmpaddr0=32'h100, pmpaddr1=32'h200; cfg2 NAPOT RWX covering all. Query addr 34'h600, write, S-mode.
  - Required: matched=1, idx=1, allow=0, response at T+3.
- No match, 8 entries all OFF:
  - U-mode read gives allow=0 at T+9.
  - M-mode read gives allow=1 at T+9.
- Locked M-mode:
  - Setup: cfg0=8'h98 (L, NAPOT, no perms), pmpaddr0=32'hFFFF_FFFF.
  - M-mode write gives allow=0, idx=0. With L cleared (cfg0=8'h18), the same query gives allow=1.
- Backpressure and mid-op reset: hold `resp_ready_i`=0 for 5 cycles; outputs stay stable and `req_ready_o`=0. Assert `rst_ni`=0 for one cycle; next cycle `resp_valid_o`=0, `req_ready_o`=1 and, with the macro defined, `deny_cnt_o`=0.
